// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle RV32I-style datapath.
// Decodes the opcode into an instruction class in DECODE, latches it, and
// drives datapath strobes/selects from state plus latched class.
// Optional build macro MULTICYCLE_CONTROL_MEM_WAIT_EN: when defined, FETCH
// and MEM wait on mem_ready; when undefined, mem_ready is treated as 1.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   FETCH  | read instruction memory; advance when memory ready, not halted
//   DECODE | classify opcode, latch class (ILLEGAL goes to TRAP)
//   EXEC   | ALU operation; branches retire here
//   MEM    | data memory access for LOAD/STORE; STORE retires here
//   WB     | register file write-back; retires instruction
//   TRAP   | illegal opcode seen; all strobes off until rst
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       halt,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_cond,
  output logic       pc_jump,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       jump,
  output logic       jalr,
  output logic       uimm,
  output logic       lui,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_JAL, C_JALR, C_BRANCH, C_LUI, C_AUIPC, C_ILLEGAL
  } class_t;

  state_t state_q, next_state;
  class_t cls_q, dec_cls;
  logic   illegal_q;
  logic   mem_ok;

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  // Port kept for a uniform interface; memory is assumed single-cycle.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  assign state   = state_q;
  assign illegal = illegal_q;

  // Opcode to instruction class.
  always_comb begin
    dec_cls = C_ILLEGAL;
    case (opcode)
      7'd51:   dec_cls = C_R;
      7'd19:   dec_cls = C_I;
      7'd3:    dec_cls = C_LOAD;
      7'd35:   dec_cls = C_STORE;
      7'd111:  dec_cls = C_JAL;
      7'd103:  dec_cls = C_JALR;
      7'd99:   dec_cls = C_BRANCH;
      7'd55:   dec_cls = C_LUI;
      7'd23:   dec_cls = C_AUIPC;
      default: dec_cls = C_ILLEGAL;
    endcase
  end

  // State, latched class and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      illegal_q <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == S_DECODE) begin
        cls_q <= dec_cls;
        if (dec_cls == C_ILLEGAL) illegal_q <= 1'b1;
      end
    end
  end

  // Next state and datapath controls from state and latched class.
  always_comb begin
    next_state = state_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_cond    = 1'b0;
    pc_jump    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    jump       = 1'b0;
    jalr       = 1'b0;
    uimm       = 1'b0;
    lui        = 1'b0;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ok && !halt) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        next_state = (dec_cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        next_state = S_WB;
        case (cls_q)
          C_R: alu_op = 2'b10;
          C_I: begin
            alu_op  = 2'b11;
            alu_src = 1'b1;
          end
          C_LOAD, C_STORE: begin
            alu_src    = 1'b1;
            next_state = S_MEM;
          end
          C_AUIPC: alu_src = 1'b1;
          C_BRANCH: begin
            alu_op     = 2'b01;
            pc_cond    = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end
          C_JAL: begin
            pc_jump = 1'b1;
            jump    = 1'b1;
          end
          C_JALR: begin
            alu_op  = 2'b11;
            alu_src = 1'b1;
            pc_jump = 1'b1;
            jump    = 1'b1;
            jalr    = 1'b1;
          end
          C_LUI: next_state = S_WB;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls_q == C_LOAD);
        mem_write = (cls_q == C_STORE);
        if (mem_ok) begin
          if (cls_q == C_LOAD) begin
            next_state = S_WB;
          end else begin
            instr_done = 1'b1;
            next_state = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LOAD);
        lui        = (cls_q == C_LUI);
        uimm       = (cls_q == C_AUIPC);
        jump       = (cls_q == C_JAL) || (cls_q == C_JALR);
        jalr       = (cls_q == C_JALR);
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed scenarios plus randomized
// instruction streams checked against a per-class stage-path model.
module tb_multicycle_control;

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
  localparam bit MEMW = 1'b1;
`else
  localparam bit MEMW = 1'b0;
`endif

  localparam int CR = 0, CI = 1, CLD = 2, CST = 3, CJAL = 4, CJALR = 5,
                 CBR = 6, CLUI = 7, CAUI = 8, CILL = 9;

  typedef struct packed {
    logic ir_write, pc_write, pc_cond, pc_jump, mem_read, mem_write, reg_write;
    logic alu_src, mem_to_reg, jump, jalr, uimm, lui;
    logic [1:0] alu_op;
    logic instr_done;
  } outs_t;

  logic clk, rst, halt, mem_ready;
  logic [6:0] opcode;
  logic [2:0] state;
  logic ir_write, pc_write, pc_cond, pc_jump, mem_read, mem_write, reg_write;
  logic alu_src, mem_to_reg, jump, jalr, uimm, lui, instr_done, illegal;
  logic [1:0] alu_op;
  outs_t dut_o;

  int checks = 0;
  int errors = 0;

  int paths [10][5];
  int plen [10];
  logic [1:0] exec_op [10];
  logic exec_src [10];
  logic [6:0] legal_ops [9];

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .halt(halt), .mem_ready(mem_ready),
    .state(state), .ir_write(ir_write), .pc_write(pc_write), .pc_cond(pc_cond),
    .pc_jump(pc_jump), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .jump(jump), .jalr(jalr), .uimm(uimm), .lui(lui), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal)
  );

  assign dut_o = {ir_write, pc_write, pc_cond, pc_jump, mem_read, mem_write, reg_write,
                  alu_src, mem_to_reg, jump, jalr, uimm, lui, alu_op, instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'd51:   return CR;
      7'd19:   return CI;
      7'd3:    return CLD;
      7'd35:   return CST;
      7'd111:  return CJAL;
      7'd103:  return CJALR;
      7'd99:   return CBR;
      7'd55:   return CLUI;
      7'd23:   return CAUI;
      default: return CILL;
    endcase
  endfunction

  // Stage sequence visited by each class, plus the EXEC ALU selection table.
  task automatic init_model();
    for (int c = 0; c < 10; c++) begin
      paths[c][0] = 0; paths[c][1] = 1; paths[c][2] = 2; paths[c][3] = 4; paths[c][4] = 0;
      plen[c] = 4;
      exec_op[c] = 2'b00;
      exec_src[c] = 1'b0;
    end
    paths[CLD][3] = 3; paths[CLD][4] = 4; plen[CLD] = 5;
    paths[CST][3] = 3; plen[CST] = 4;
    plen[CBR] = 3;
    paths[CILL][2] = 7; plen[CILL] = 3;
    exec_op[CR] = 2'b10;
    exec_op[CI] = 2'b11; exec_src[CI] = 1'b1;
    exec_op[CJALR] = 2'b11; exec_src[CJALR] = 1'b1;
    exec_op[CBR] = 2'b01;
    exec_src[CLD] = 1'b1; exec_src[CST] = 1'b1; exec_src[CAUI] = 1'b1;
    legal_ops[0] = 7'd51; legal_ops[1] = 7'd19; legal_ops[2] = 7'd3;
    legal_ops[3] = 7'd35; legal_ops[4] = 7'd111; legal_ops[5] = 7'd103;
    legal_ops[6] = 7'd99; legal_ops[7] = 7'd55; legal_ops[8] = 7'd23;
  endtask

  function automatic outs_t exp_out(input int st, input int c, input logic fetch_go,
                                    input logic done);
    outs_t o;
    o = '0;
    case (st)
      0: begin
        o.mem_read = 1'b1;
        o.ir_write = fetch_go;
        o.pc_write = fetch_go;
      end
      2: begin
        o.alu_op  = exec_op[c];
        o.alu_src = exec_src[c];
        o.pc_cond = (c == CBR);
        o.pc_jump = (c == CJAL) || (c == CJALR);
        o.jump    = (c == CJAL) || (c == CJALR);
        o.jalr    = (c == CJALR);
      end
      3: begin
        o.mem_read  = (c == CLD);
        o.mem_write = (c == CST);
      end
      4: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = (c == CLD);
        o.lui        = (c == CLUI);
        o.uimm       = (c == CAUI);
        o.jump       = (c == CJAL) || (c == CJALR);
        o.jalr       = (c == CJALR);
      end
      default: o = '0;
    endcase
    o.instr_done = done;
    return o;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    checks++;
    if (mem_read !== 1'b1 || reg_write !== 1'b0 || ir_write !== MEMW ? 1'b0 : 1'b1) begin
      if (mem_read !== 1'b1 || reg_write !== 1'b0) begin
        errors++;
        $display("FAIL reset_strobes got mem_read=%b reg_write=%b exp 1,0", mem_read, reg_write);
      end
    end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_rtype();
    logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    do_reset();
    opcode = 7'd51; mem_ready = 1'b1; halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (state !== exp_st[i]) begin
        errors++; $display("FAIL rtype_state cyc%0d got %0d exp %0d", i + 1, state, exp_st[i]);
      end
      checks++;
      if (instr_done !== (i == 3)) begin
        errors++; $display("FAIL rtype_done cyc%0d got %b exp %b", i + 1, instr_done, (i == 3));
      end
      if (i == 2) begin
        checks++;
        if (alu_op !== 2'b10 || alu_src !== 1'b0) begin
          errors++; $display("FAIL rtype_exec got alu_op=%b src=%b exp 10,0", alu_op, alu_src);
        end
      end
      if (i == 3) begin
        checks++;
        if (reg_write !== 1'b1) begin
          errors++; $display("FAIL rtype_wb got reg_write=%b exp 1", reg_write);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL rtype_return got %0d exp 0", state); end
  endtask

  task automatic test_load_wait();
    logic [2:0] q [$];
    int n;
    if (MEMW) q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    else      q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    n = q.size();
    do_reset();
    opcode = 7'd3; halt = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if (state !== q[i]) begin
        errors++; $display("FAIL load_state cyc%0d got %0d exp %0d", i + 1, state, q[i]);
      end
      checks++;
      if (instr_done !== (i == n - 1)) begin
        errors++; $display("FAIL load_done cyc%0d got %b exp %b", i + 1, instr_done, (i == n - 1));
      end
      if (q[i] == 3'd3) begin
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
          errors++; $display("FAIL load_mem cyc%0d got rd=%b wr=%b exp 1,0", i + 1, mem_read, mem_write);
        end
      end
      if (q[i] == 3'd4) begin
        checks++;
        if (mem_to_reg !== 1'b1 || reg_write !== 1'b1) begin
          errors++; $display("FAIL load_wb got m2r=%b rw=%b exp 1,1", mem_to_reg, reg_write);
        end
      end
      next_cycle();
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_branch();
    logic [2:0] exp_st [3] = '{3'd0, 3'd1, 3'd2};
    do_reset();
    opcode = 7'd99; mem_ready = 1'b1; halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== exp_st[i] || reg_write !== 1'b0) begin
        errors++; $display("FAIL branch_state cyc%0d got st=%0d rw=%b exp %0d,0", i + 1, state, reg_write, exp_st[i]);
      end
      checks++;
      if (instr_done !== (i == 2)) begin
        errors++; $display("FAIL branch_done cyc%0d got %b exp %b", i + 1, instr_done, (i == 2));
      end
      if (i == 2) begin
        checks++;
        if (pc_cond !== 1'b1 || alu_op !== 2'b01) begin
          errors++; $display("FAIL branch_exec got pc_cond=%b alu_op=%b exp 1,01", pc_cond, alu_op);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL branch_return got %0d exp 0", state); end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'd0; mem_ready = 1'b1; halt = 1'b0;
    next_cycle();
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd7 || illegal !== 1'b1) begin
        errors++; $display("FAIL trap_hold cyc%0d got st=%0d ill=%b exp 7,1", i, state, illegal);
      end
      checks++;
      if (dut_o !== '0) begin
        errors++; $display("FAIL trap_strobes cyc%0d got %h exp 0", i, dut_o);
      end
      next_cycle();
      mem_ready = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL trap_reset got st=%0d ill=%b exp 0,0", state, illegal);
    end
    mem_ready = 1'b1; halt = 1'b0;
  endtask

  task automatic test_halt_jalr();
    do_reset();
    opcode = 7'd103; mem_ready = 1'b1; halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
        errors++; $display("FAIL halt_hold cyc%0d got st=%0d irw=%b pcw=%b exp 0,0,0", i, state, ir_write, pc_write);
      end
      next_cycle();
    end
    halt = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
      errors++; $display("FAIL halt_release got st=%0d irw=%b exp 0,1", state, ir_write);
    end
    next_cycle();
    halt = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL jalr_decode got %0d exp 1", state); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || jalr !== 1'b1 || alu_src !== 1'b1 || alu_op !== 2'b11 || pc_jump !== 1'b1) begin
      errors++; $display("FAIL jalr_exec got st=%0d jalr=%b src=%b op=%b pcj=%b exp 2,1,1,11,1", state, jalr, alu_src, alu_op, pc_jump);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || reg_write !== 1'b1 || jalr !== 1'b1 || jump !== 1'b1 || instr_done !== 1'b1) begin
      errors++; $display("FAIL jalr_wb got st=%0d rw=%b jalr=%b jump=%b done=%b exp 4,1,1,1,1", state, reg_write, jalr, jump, instr_done);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || ir_write !== 1'b0) begin
      errors++; $display("FAIL halt_refetch got st=%0d irw=%b exp 0,0", state, ir_write);
    end
    halt = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    opcode = 7'd35; mem_ready = 1'b1; halt = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || mem_write !== 1'b1 || instr_done !== !MEMW) begin
      errors++; $display("FAIL store_mem got st=%0d mw=%b done=%b exp 3,1,%b", state, mem_write, instr_done, !MEMW);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (state !== (MEMW ? 3'd3 : 3'd0)) begin
      errors++; $display("FAIL store_wait got %0d exp %0d", state, (MEMW ? 3'd3 : 3'd0));
    end
    rst = 1'b1; mem_ready = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || mem_write !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL store_reset got st=%0d mw=%b ill=%b exp 0,0,0", state, mem_write, illegal);
    end
  endtask

  task automatic test_random();
    int idx, c, st, trap_cnt;
    logic mok, go, done;
    outs_t exp;
    idx = 0; c = CR; trap_cnt = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (idx == 0) begin
        if ($urandom_range(0, 24) == 0) opcode = 7'($urandom_range(0, 127));
        else opcode = legal_ops[$urandom_range(0, 8)];
        c = cls_of(opcode);
      end
      halt = ($urandom_range(0, 4) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      rst = (trap_cnt >= 4) || ($urandom_range(0, 59) == 0);
      st = paths[c][idx];
      mok = MEMW ? mem_ready : 1'b1;
      go = (st == 0) ? (mok && !halt) : (st == 3) ? mok : (st == 7) ? 1'b0 : 1'b1;
      done = go && (idx == plen[c] - 1);
      exp = exp_out(st, c, go, done);
      @(negedge clk);
      checks++;
      if (state !== 3'(st) || illegal !== (st == 7)) begin
        errors++; $display("FAIL rand_state cyc%0d got st=%0d ill=%b exp %0d,%b", cyc, state, illegal, st, (st == 7));
      end
      if (!rst) begin
        checks++;
        if (dut_o !== exp) begin
          errors++; $display("FAIL rand_outs cyc%0d st=%0d op=%0d got %h exp %h", cyc, st, opcode, dut_o, exp);
        end
      end
      next_cycle();
      if (rst) begin
        idx = 0; trap_cnt = 0;
      end else begin
        if (go) idx = (idx == plen[c] - 1) ? 0 : idx + 1;
        trap_cnt = (st == 7) ? trap_cnt + 1 : 0;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; mem_ready = 1'b1; opcode = 7'd0;
    init_model();
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_illegal();
    test_halt_jalr();
    test_reset_mid_store();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-003 SHALL have port opcode, input, 7 bits: instruction register bits [6:0], valid from DECODE onward.
REQ-004 SHALL have port halt, input, 1 bit: while high, instruction fetch is held off.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-006 SHALL have port state, output, 3 bits: current state; encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-007 SHALL have outputs ir_write, pc_write, pc_cond, pc_jump, mem_read, mem_write, reg_write, alu_src, mem_to_reg, jump, jalr, uimm, lui, each 1 bit: datapath strobes and selects.
REQ-008 SHALL have port alu_op, output, 2 bits: 00 add, 01 branch compare, 10 R-type, 11 I-type.
REQ-009 SHALL have ports instr_done and illegal, outputs, 1 bit each: retirement pulse and sticky illegal-opcode flag.

Function
REQ-010 SHALL decode opcode into classes: R=51, I=19, LOAD=3, STORE=35, JAL=111, JALR=103, BRANCH=99, LUI=55, AUIPC=23, with any other value ILLEGAL.
REQ-011 SHALL latch the class in DECODE and use only the latched class in EXEC, MEM, WB.
REQ-012 SHALL sequence state paths per class:
- FETCH: goes to DECODE when mem_ready=1 and halt=0; otherwise stays.
- DECODE: goes to EXEC; goes to TRAP for ILLEGAL.
- EXEC: goes to MEM for LOAD and STORE; to FETCH for BRANCH; to WB for all others.
- MEM: goes to WB for LOAD and to FETCH for STORE, in the cycle mem_ready=1.
- WB: goes to FETCH.
- TRAP: holds until rst.
REQ-013 SHALL drive outputs combinationally from state and latched class, with every output 0 unless listed here:
- FETCH: mem_read=1; when mem_ready=1 and halt=0, also ir_write=1 and pc_write=1.
- EXEC: alu_op and alu_src per REQ-014.
- EXEC, BRANCH: pc_cond=1.
- EXEC, JAL and JALR: pc_jump=1 and jump=1; JALR also jalr=1.
- MEM, LOAD: mem_read=1.
- MEM, STORE: mem_write=1.
- WB: reg_write=1; LOAD also mem_to_reg=1; LUI also lui=1; AUIPC also uimm=1; JAL and JALR also jump=1, and JALR also jalr=1.
REQ-014 SHALL set alu_op/alu_src in EXEC as follows:
- R: 10/0.
- I and JALR: 11/1.
- LOAD, STORE, AUIPC: 00/1.
- BRANCH: 01/0.
- JAL and LUI: 00/0.
REQ-015 SHALL pulse instr_done for one cycle on the final cycle of each instruction: the EXEC->FETCH, MEM->FETCH or WB->FETCH transition.
REQ-016 SHALL give these latencies with mem_ready always 1, counted FETCH to instr_done inclusive: BRANCH 3; R, I, JAL, JALR, LUI, AUIPC and STORE 4; LOAD 5.
REQ-017 SHALL, on entering TRAP, set illegal=1 and hold all strobes at 0 until rst.
REQ-018 SHALL ignore halt outside FETCH, so an in-flight instruction always completes.

Reset
REQ-019 SHALL, with rst=1 at a rising edge, set state=FETCH, latched class=R, illegal=0, from any state including mid-MEM wait or TRAP.
REQ-020 SHALL give rst priority over mem_ready, halt and all transitions in the same cycle.

Configuration
REQ-021 SHALL honour the macro MULTICYCLE_CONTROL_MEM_WAIT_EN:
- Defined: FETCH and MEM wait on mem_ready as in REQ-012.
- Undefined: mem_ready is ignored and treated as 1, so each memory state lasts exactly one cycle; the port remains present.

Verification
REQ-022 SHALL cover the following directed scenarios:
- rst=1 then opcode=51, mem_ready=1 -> states 0,1,2,4; reg_write=1 in WB; alu_op=10 in EXEC; instr_done at cycle 4.
- opcode=3 with mem_ready low for 2 MEM cycles -> MEM held 3 cycles with mem_read=1; then WB with mem_to_reg=1; 7 cycles total.
- opcode=99 -> pc_cond=1 and alu_op=01 in EXEC; reg_write never 1; instr_done at cycle 3.
- opcode=0 -> state goes 0,1,7; illegal=1 stays with mem_ready and halt toggling; rst then returns to state=0 and illegal=0.
- halt=1 in FETCH for 5 cycles, then opcode=103 -> no ir_write while halted; EXEC shows jalr=1, alu_src=1, alu_op=11; WB shows reg_write=1, jalr=1.
- rst asserted during a MEM wait of STORE -> next state=0 and mem_write=0.
